// File: rtl/ddr3_avl_tester.sv
// ddr3_avl_tester
//   Self-contained memory tester for an Avalon-MM DDR3 controller port. After
//   calibration it writes NUM_WORDS words of a seeded pattern starting at
//   BASE_ADDR. It then reads them back with up to MAX_OUT reads in flight and
//   compares every beat against the expected pattern.
//
// Ports
//   clk_i, reset_n_i            clock, asynchronous active-low reset
//   start_i                     one-cycle run request (honoured in idle/done only)
//   init_done_i, cal_success_i,
//   cal_fail_i                  memory-controller calibration status
//   avl_address_o, avl_write_o,
//   avl_read_o, avl_writedata_o,
//   avl_byteenable_o            Avalon master request side (byteenable fixed 8'hFF)
//   avl_waitrequest_i,
//   avl_readdata_i,
//   avl_readdatavalid_i         Avalon master response side
//   busy_o, done_o, pass_o,
//   fail_o                      run status
//   err_count_o                 saturating mismatch count
//   first_err_idx_o             word index of the first mismatch of the run
module ddr3_avl_tester #(
    parameter int unsigned ADDR_W    = 24,
    parameter int unsigned NUM_WORDS = 1024,
    parameter int unsigned BASE_ADDR = 0,
    parameter logic [31:0] SEED      = 32'hA5A5_0F0F,
    parameter int unsigned MAX_OUT   = 8,
    parameter int unsigned TIMEOUT   = 4096
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              start_i,
    input  logic              init_done_i,
    input  logic              cal_success_i,
    input  logic              cal_fail_i,
    output logic [ADDR_W-1:0] avl_address_o,
    output logic              avl_write_o,
    output logic              avl_read_o,
    output logic [63:0]       avl_writedata_o,
    output logic [7:0]        avl_byteenable_o,
    input  logic              avl_waitrequest_i,
    input  logic [63:0]       avl_readdata_i,
    input  logic              avl_readdatavalid_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic              fail_o,
    output logic [15:0]       err_count_o,
    output logic [ADDR_W-1:0] first_err_idx_o
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WORDS - 1);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [3:0]        OUT_MAX  = 4'(MAX_OUT);
    localparam logic [31:0]       WD_LAST  = 32'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StWaitCal,
        StWrite,
        StRead,
        StDrain,
        StDone
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] wi_q, ri_q, ci_q;
    logic [3:0]        out_q, out_d;
    logic [31:0]       wd_q;
    logic [ADDR_W-1:0] avl_address_q;
    logic              avl_write_q, avl_read_q;
    logic [63:0]       avl_writedata_q;
    logic              busy_q, done_q, pass_q, fail_q;
    logic [15:0]       err_count_q;
    logic [ADDR_W-1:0] first_err_idx_q;

    logic rd_acc, wr_acc, beat, wd_hit, mismatch, rd_want;

    // Expected word: seeded index in the low half, its complement in the high half.
    function automatic logic [63:0] pattern(input logic [ADDR_W-1:0] idx);
        logic [31:0] x;
        x = 32'(idx) ^ SEED;
        return {~x, x};
    endfunction

    // Address wraps modulo 2^ADDR_W through the natural width of the sum.
    function automatic logic [ADDR_W-1:0] addr_of(input logic [ADDR_W-1:0] idx);
        return BASE + idx;
    endfunction

    always_comb begin
        wr_acc   = avl_write_q && !avl_waitrequest_i;
        rd_acc   = avl_read_q && !avl_waitrequest_i;
        // Beats with nothing in flight (e.g. stale data from before a reset) are dropped.
        beat     = avl_readdatavalid_i && (out_q != 4'd0);
        out_d    = out_q;
        if (rd_acc && !beat) begin
            out_d = out_q + 4'd1;
        end else if (!rd_acc && beat) begin
            out_d = out_q - 4'd1;
        end
        rd_want  = out_d < OUT_MAX;
        wd_hit   = (out_q != 4'd0) && !beat && (wd_q == WD_LAST);
        mismatch = beat && (avl_readdata_i != pattern(ci_q));
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q         <= StIdle;
            wi_q            <= '0;
            ri_q            <= '0;
            ci_q            <= '0;
            out_q           <= 4'd0;
            wd_q            <= 32'd0;
            avl_address_q   <= '0;
            avl_write_q     <= 1'b0;
            avl_read_q      <= 1'b0;
            avl_writedata_q <= 64'd0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            pass_q          <= 1'b0;
            fail_q          <= 1'b0;
            err_count_q     <= 16'd0;
            first_err_idx_q <= '0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start_i) begin
                        state_q         <= StWaitCal;
                        wi_q            <= '0;
                        ri_q            <= '0;
                        ci_q            <= '0;
                        out_q           <= 4'd0;
                        wd_q            <= 32'd0;
                        busy_q          <= 1'b1;
                        done_q          <= 1'b0;
                        pass_q          <= 1'b0;
                        fail_q          <= 1'b0;
                        err_count_q     <= 16'd0;
                        first_err_idx_q <= '0;
                    end
                end

                StWaitCal: begin
                    if (cal_fail_i) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        fail_q  <= 1'b1;
                    end else if (init_done_i && cal_success_i) begin
                        state_q         <= StWrite;
                        avl_write_q     <= 1'b1;
                        avl_address_q   <= addr_of('0);
                        avl_writedata_q <= pattern('0);
                    end
                end

                StWrite: begin
                    // Request stays untouched while stalled; advance only on acceptance.
                    if (wr_acc) begin
                        if (wi_q == LAST_IDX) begin
                            state_q       <= StRead;
                            avl_write_q   <= 1'b0;
                            avl_read_q    <= 1'b1;
                            avl_address_q <= addr_of('0);
                        end else begin
                            wi_q            <= wi_q + 1'b1;
                            avl_address_q   <= addr_of(wi_q + 1'b1);
                            avl_writedata_q <= pattern(wi_q + 1'b1);
                        end
                    end
                end

                StRead, StDrain: begin
                    out_q <= out_d;

                    if (beat) begin
                        ci_q <= ci_q + 1'b1;
                        if (mismatch) begin
                            if (err_count_q == 16'd0) begin
                                first_err_idx_q <= ci_q;
                            end
                            if (err_count_q != 16'hFFFF) begin
                                err_count_q <= err_count_q + 16'd1;
                            end
                        end
                    end

                    if (beat || out_q == 4'd0) begin
                        wd_q <= 32'd0;
                    end else begin
                        wd_q <= wd_q + 32'd1;
                    end

                    if (wd_hit) begin
                        // Give up on everything still in flight.
                        state_q    <= StDone;
                        out_q      <= 4'd0;
                        avl_read_q <= 1'b0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        pass_q     <= 1'b0;
                        fail_q     <= 1'b1;
                    end else if (state_q == StDrain) begin
                        if (out_q == 4'd0) begin
                            state_q <= StDone;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_count_q == 16'd0);
                            fail_q  <= (err_count_q != 16'd0);
                        end
                    end else if (avl_read_q && avl_waitrequest_i) begin
                        // Stalled read: hold address and strobe.
                    end else if (avl_read_q) begin
                        if (ri_q == LAST_IDX) begin
                            state_q    <= StDrain;
                            avl_read_q <= 1'b0;
                        end else begin
                            ri_q          <= ri_q + 1'b1;
                            avl_address_q <= addr_of(ri_q + 1'b1);
                            avl_read_q    <= rd_want;
                        end
                    end else begin
                        avl_address_q <= addr_of(ri_q);
                        avl_read_q    <= rd_want;
                    end
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign avl_address_o    = avl_address_q;
    assign avl_write_o      = avl_write_q;
    assign avl_read_o       = avl_read_q;
    assign avl_writedata_o  = avl_writedata_q;
    assign avl_byteenable_o = 8'hFF;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign pass_o           = pass_q;
    assign fail_o           = fail_q;
    assign err_count_o      = err_count_q;
    assign first_err_idx_o  = first_err_idx_q;

endmodule

// File: tb/tb_ddr3_avl_tester.sv
// Directed bench for ddr3_avl_tester with a small Avalon memory model.
// The memory occupies 16 words starting at 24'hFFFFF8 so the run wraps past
// the top of the address space.
module tb_ddr3_avl_tester;

    localparam int unsigned    NW   = 16;
    localparam int unsigned    MOUT = 4;
    localparam logic [23:0]    BASE = 24'hFFFFF8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        start = 1'b0;
    logic        init_done = 1'b1, cal_success = 1'b1, cal_fail = 1'b0;
    logic [23:0] avl_address;
    logic        avl_write, avl_read;
    logic [63:0] avl_writedata;
    logic [7:0]  avl_byteenable;
    logic        waitreq = 1'b0;
    logic [63:0] rddata = 64'd0;
    logic        rdvalid = 1'b0;
    logic        busy, done, pass, fail;
    logic [15:0] err_count;
    logic [23:0] first_err_idx;

    ddr3_avl_tester #(
        .ADDR_W   (24),
        .NUM_WORDS(NW),
        .BASE_ADDR(32'h00FF_FFF8),
        .SEED     (32'hA5A5_0F0F),
        .MAX_OUT  (MOUT),
        .TIMEOUT  (64)
    ) dut (
        .clk_i              (clk),
        .reset_n_i          (reset_n),
        .start_i            (start),
        .init_done_i        (init_done),
        .cal_success_i      (cal_success),
        .cal_fail_i         (cal_fail),
        .avl_address_o      (avl_address),
        .avl_write_o        (avl_write),
        .avl_read_o         (avl_read),
        .avl_writedata_o    (avl_writedata),
        .avl_byteenable_o   (avl_byteenable),
        .avl_waitrequest_i  (waitreq),
        .avl_readdata_i     (rddata),
        .avl_readdatavalid_i(rdvalid),
        .busy_o             (busy),
        .done_o             (done),
        .pass_o             (pass),
        .fail_o             (fail),
        .err_count_o        (err_count),
        .first_err_idx_o    (first_err_idx)
    );

    always #5 clk = ~clk;

    // Model configuration
    int wait_mode   = 0;   // 0 never stall, 1 random 50%, 2 always stall
    int latency     = 1;
    int corrupt_en  = 0;
    int drop_idx    = -1;

    // Model observations
    logic [63:0] mem [NW];
    logic [23:0] wr_addr [NW];
    logic [63:0] wr_data [NW];
    int q_due[$];
    int q_idx[$];
    int cyc = 0;
    int wr_cnt, rd_acc, beats, first_wr_cyc, last_wr_cyc, last_beat_cyc, fail_cyc;
    int max_out, stall_viol, overlap;
    logic        prev_stall_wr = 1'b0, prev_stall_rd = 1'b0;
    logic [23:0] prev_addr = '0;
    logic [63:0] prev_data = '0;

    int n_chk = 0;
    int n_err = 0;

    function automatic int idx_of(input logic [23:0] a);
        logic [23:0] d;
        d = a - BASE;
        return (d < 24'(NW)) ? int'(d) : 0;
    endfunction

    // Everything the memory does happens on the falling edge, so the DUT sees
    // stable waitrequest/readdata at the following rising edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!reset_n) begin
            q_due.delete();
            q_idx.delete();
            rdvalid       = 1'b0;
            prev_stall_wr = 1'b0;
            prev_stall_rd = 1'b0;
        end else begin
            case (wait_mode)
                1:       waitreq = 1'($urandom_range(0, 1));
                2:       waitreq = 1'b1;
                default: waitreq = 1'b0;
            endcase
            if (avl_write && avl_read) overlap++;
            if (prev_stall_wr && !(avl_write && avl_address == prev_addr
                                   && avl_writedata == prev_data)) stall_viol++;
            if (prev_stall_rd && !(avl_read && avl_address == prev_addr)) stall_viol++;
            prev_stall_wr = avl_write && waitreq;
            prev_stall_rd = avl_read && waitreq;
            prev_addr     = avl_address;
            prev_data     = avl_writedata;

            if (avl_write && !waitreq) begin
                mem[idx_of(avl_address)] = avl_writedata;
                if (wr_cnt < int'(NW)) begin
                    wr_addr[wr_cnt] = avl_address;
                    wr_data[wr_cnt] = avl_writedata;
                end
                if (wr_cnt == 0) first_wr_cyc = cyc;
                last_wr_cyc = cyc;
                wr_cnt++;
            end

            rdvalid = 1'b0;
            if (q_due.size() > 0 && q_due[0] <= cyc) begin
                int i;
                i = q_idx[0];
                void'(q_due.pop_front());
                void'(q_idx.pop_front());
                if (i != drop_idx) begin
                    rdvalid = 1'b1;
                    rddata  = mem[i];
                    if (corrupt_en != 0 && (i == 5 || i == 9)) rddata[0] = ~rddata[0];
                    last_beat_cyc = cyc;
                    beats++;
                end
            end
            if (avl_read && !waitreq) begin
                q_due.push_back(cyc + latency);
                q_idx.push_back(idx_of(avl_address));
                rd_acc++;
            end
            if (rd_acc - beats > max_out) max_out = rd_acc - beats;
            if (fail && fail_cyc < 0) fail_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_run();
        @(negedge clk);
        #1;
        wr_cnt = 0; rd_acc = 0; beats = 0; first_wr_cyc = -1; last_wr_cyc = -1;
        last_beat_cyc = -1; fail_cyc = -1; max_out = 0; stall_viol = 0; overlap = 0;
        start = 1'b1;
        @(negedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", busy, 1);
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("run_done", done, 1);
        repeat (2) @(negedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #3 reset_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_fail", fail, 0);
        check("rst_write", avl_write, 0);
        check("rst_read", avl_read, 0);
        check("rst_be", avl_byteenable, 8'hFF);
        check("rst_errcnt", err_count, 0);
        check("rst_addr", avl_address, 0);
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;

        // Ideal zero-wait memory
        start_run();
        wait_done(1000);
        check("ideal_pass", pass, 1);
        check("ideal_fail", fail, 0);
        check("ideal_busy", busy, 0);
        check("ideal_errcnt", err_count, 0);
        check("ideal_wr_cnt", wr_cnt, 16);
        check("ideal_wr_span", last_wr_cyc - first_wr_cyc, 15);
        check("ideal_beats", beats, 16);
        check("ideal_wr0_addr", wr_addr[0], 24'hFFFFF8);
        check("ideal_wr0_data", wr_data[0], 64'h5A5AF0F0_A5A50F0F);
        check("ideal_wr8_addr", wr_addr[8], 24'h000000);
        check("ideal_wr9_data", wr_data[9], 64'h5A5AF0F9_A5A50F06);
        check("ideal_overlap", overlap, 0);

        // Random stalls, read latency 7
        wait_mode = 1;
        latency   = 7;
        start_run();
        wait_done(3000);
        check("stall_pass", pass, 1);
        check("stall_errcnt", err_count, 0);
        check("stall_stable", stall_viol, 0);
        check("stall_maxout_ok", max_out <= int'(MOUT), 1);
        check("stall_rd_acc", rd_acc, 16);
        check("stall_overlap", overlap, 0);

        // Bit 0 corrupted at index 5 and 9
        wait_mode  = 0;
        latency    = 1;
        corrupt_en = 1;
        start_run();
        wait_done(1000);
        check("corr_fail", fail, 1);
        check("corr_pass", pass, 0);
        check("corr_errcnt", err_count, 2);
        check("corr_first", first_err_idx, 5);
        corrupt_en = 0;

        // Last read response dropped: watchdog fires 64 edges after the last
        // beat's sampling edge, seen one negedge after that (hence 65).
        drop_idx = 15;
        start_run();
        wait_done(1000);
        check("drop_fail", fail, 1);
        check("drop_pass", pass, 0);
        check("drop_errcnt", err_count, 0);
        check("drop_beats", beats, 15);
        check("drop_delay", fail_cyc - last_beat_cyc, 65);
        drop_idx = -1;

        // Calibration failure wins over success
        cal_fail = 1'b1;
        start_run();
        wait_done(100);
        check("cal_fail", fail, 1);
        check("cal_pass", pass, 0);
        check("cal_no_write", wr_cnt, 0);
        cal_fail = 1'b0;

        // Reset in the middle of a stalled write, then a clean rerun
        wait_mode = 2;
        start_run();
        repeat (4) @(negedge clk);
        check("mid_write_active", avl_write, 1);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_write", avl_write, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_be", avl_byteenable, 8'hFF);
        @(negedge clk);
        #1 reset_n = 1'b1;
        wait_mode = 0;
        start_run();
        wait_done(1000);
        check("rerun_pass", pass, 1);
        check("rerun_errcnt", err_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
